mem_stage_sramlike: RTL and testbench

- Next-generation MEM pipeline stage for the sram-like data interface, where load/store data returns on a later `data_ok` handshake instead of a fixed cycle.
- Holds one instruction from EX and waits for its memory response. Performs byte/half/word load extraction, forwards results to ID and hands off to WB.
- Discards late responses belonging to instructions flushed by `wb_ex`.

---
 rtl/mem_stage_sramlike.sv | 142 ++++++++++++++
 tb/tb_mem_stage_sramlike.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sramlike.sv
// MEM stage for the sram-like data interface: holds one instruction until its
// data_ok arrives, extracts load data, forwards to ID and hands off to WB.
module mem_stage_sramlike #(
  parameter int EX_W         = 86,
  parameter int DISCARD_W    = 2,
  parameter bit BYPASS_RDATA = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [31:0]          es_pc,
  input  logic                 es_mem_req,
  input  logic                 es_res_from_mem,
  input  logic [4:0]           es_ld_op,
  input  logic [31:0]          es_result,
  input  logic                 es_rf_we,
  input  logic [4:0]           es_rf_waddr,
  input  logic                 es_csr_re,
  input  logic [EX_W-1:0]      es_ex_zip,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  input  logic                 wb_ex,
  output logic                 ms_to_ws_valid,
  output logic [31:0]          ms_pc,
  output logic                 ms_rf_we,
  output logic [4:0]           ms_rf_waddr,
  output logic [31:0]          ms_rf_wdata,
  output logic                 ms_res_valid,
  output logic [31:0]          ms_result,
  output logic                 ms_csr_re,
  output logic [EX_W-1:0]      ms_ex_zip,
  output logic                 ms_ex,
  output logic                 ms_discard_full
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_READY
  } state_t;

  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

  state_t                state, state_nxt;
  logic [DISCARD_W-1:0]  discard_cnt;
  logic [31:0]           data_buf;
  logic                  ms_res_from_mem;
  logic [4:0]            ms_ld_op;

  logic                  dok_drop;
  logic                  dok_consume;
  logic                  bypass_hit;
  logic                  handoff;
  logic                  accept;
  logic                  cnt_inc;
  logic [31:0]           load_word;
  logic [31:0]           shifted;
  logic [31:0]           ld_data;

  // A response is owed to a flushed instruction whenever the counter is nonzero.
  assign dok_drop    = data_sram_data_ok & (discard_cnt != '0);
  assign dok_consume = data_sram_data_ok & (discard_cnt == '0) & (state == S_WAIT);
  assign bypass_hit  = BYPASS_RDATA ? dok_consume : 1'b0;

  assign ms_discard_full = (discard_cnt == DISCARD_MAX);
  assign ms_to_ws_valid  = ((state == S_READY) | bypass_hit) & ~wb_ex;
  assign handoff         = ms_to_ws_valid & ws_allowin;
  assign ms_allowin      = (((state == S_EMPTY) | handoff) & ~ms_discard_full) | wb_ex;
  assign accept          = es_to_ms_valid & ms_allowin & ~wb_ex;
  assign cnt_inc         = wb_ex & (state == S_WAIT) & ~dok_consume;
  assign ms_res_valid    = (state == S_READY) | dok_consume;
  assign ms_ex           = |ms_ex_zip[6:0];

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wb_ex)            state_nxt = S_EMPTY;
    else if (accept)      state_nxt = es_mem_req ? S_WAIT : S_READY;
    else if (handoff)     state_nxt = S_EMPTY;
    else if (dok_consume) state_nxt = S_READY;
  end

  // Simultaneous flush-increment and drop-decrement leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else if (cnt_inc && !dok_drop && !ms_discard_full) begin
      discard_cnt <= discard_cnt + 1'b1;
    end else if (dok_drop && !cnt_inc) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_buf        <= '0;
      ms_pc           <= '0;
      ms_res_from_mem <= 1'b0;
      ms_ld_op        <= '0;
      ms_result       <= '0;
      ms_rf_we        <= 1'b0;
      ms_rf_waddr     <= '0;
      ms_csr_re       <= 1'b0;
      ms_ex_zip       <= '0;
    end else begin
      if (dok_consume) data_buf <= data_sram_rdata;
      if (accept) begin
        ms_pc           <= es_pc;
        ms_res_from_mem <= es_res_from_mem;
        ms_ld_op        <= es_ld_op;
        ms_result       <= es_result;
        ms_rf_we        <= es_rf_we;
        ms_rf_waddr     <= es_rf_waddr;
        ms_csr_re       <= es_csr_re;
        ms_ex_zip       <= es_ex_zip;
      end else if (wb_ex || handoff) begin
        ms_rf_we        <= 1'b0;
      end
    end
  end

  // Forwarding needs the data in the data_ok cycle itself, before the buffer holds it.
  assign load_word = dok_consume ? data_sram_rdata : data_buf;
  assign shifted   = load_word >> {ms_result[1:0], 3'b000};

  always_comb begin
    ld_data = shifted;
    if (ms_ld_op[4])      ld_data = {{24{shifted[7]}}, shifted[7:0]};
    else if (ms_ld_op[3]) ld_data = {24'b0, shifted[7:0]};
    else if (ms_ld_op[2]) ld_data = {{16{shifted[15]}}, shifted[15:0]};
    else if (ms_ld_op[1]) ld_data = {16'b0, shifted[15:0]};
  end

  assign ms_rf_wdata = ms_res_from_mem ? ld_data : ms_result;

endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Bench for mem_stage_sramlike: two instances (rdata bypass on/off) share stimulus
// and are compared every cycle against a transaction-level model.
module tb_mem_stage_sramlike;

  localparam int EX_W = 86;
  localparam int DMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn, es_to_ms_valid, es_mem_req, es_res_from_mem;
  logic [31:0]     es_pc, es_result, rdata;
  logic [4:0]      es_ld_op, es_rf_waddr;
  logic            es_rf_we, es_csr_re, data_ok, ws_allowin, wb_ex;
  logic [EX_W-1:0] es_ex_zip;

  logic            o_allowin[2], o_valid[2], o_rf_we[2], o_res_valid[2];
  logic            o_csr_re[2], o_ex[2], o_full[2];
  logic [31:0]     o_pc[2], o_wdata[2], o_result[2];
  logic [4:0]      o_waddr[2];
  logic [EX_W-1:0] o_zip[2];

  mem_stage_sramlike #(.EX_W(EX_W), .DISCARD_W(2), .BYPASS_RDATA(1'b1)) u_byp1 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(o_allowin[0]),
    .es_pc(es_pc), .es_mem_req(es_mem_req), .es_res_from_mem(es_res_from_mem),
    .es_ld_op(es_ld_op), .es_result(es_result), .es_rf_we(es_rf_we),
    .es_rf_waddr(es_rf_waddr), .es_csr_re(es_csr_re), .es_ex_zip(es_ex_zip),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .ws_allowin(ws_allowin),
    .wb_ex(wb_ex), .ms_to_ws_valid(o_valid[0]), .ms_pc(o_pc[0]), .ms_rf_we(o_rf_we[0]),
    .ms_rf_waddr(o_waddr[0]), .ms_rf_wdata(o_wdata[0]), .ms_res_valid(o_res_valid[0]),
    .ms_result(o_result[0]), .ms_csr_re(o_csr_re[0]), .ms_ex_zip(o_zip[0]),
    .ms_ex(o_ex[0]), .ms_discard_full(o_full[0]));

  mem_stage_sramlike #(.EX_W(EX_W), .DISCARD_W(2), .BYPASS_RDATA(1'b0)) u_byp0 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(o_allowin[1]),
    .es_pc(es_pc), .es_mem_req(es_mem_req), .es_res_from_mem(es_res_from_mem),
    .es_ld_op(es_ld_op), .es_result(es_result), .es_rf_we(es_rf_we),
    .es_rf_waddr(es_rf_waddr), .es_csr_re(es_csr_re), .es_ex_zip(es_ex_zip),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .ws_allowin(ws_allowin),
    .wb_ex(wb_ex), .ms_to_ws_valid(o_valid[1]), .ms_pc(o_pc[1]), .ms_rf_we(o_rf_we[1]),
    .ms_rf_waddr(o_waddr[1]), .ms_rf_wdata(o_wdata[1]), .ms_res_valid(o_res_valid[1]),
    .ms_result(o_result[1]), .ms_csr_re(o_csr_re[1]), .ms_ex_zip(o_zip[1]),
    .ms_ex(o_ex[1]), .ms_discard_full(o_full[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 96'(act), 96'(exp));
  endtask
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, 96'(act), 96'(exp));
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [31:0]     pc;
    logic            rfm;
    logic [4:0]      ld;
    logic [31:0]     res;
    logic            we;
    logic [4:0]      wa;
    logic            csr;
    logic [EX_W-1:0] zip;
  } rec_t;

  rec_t        rec[2];
  bit          busy[2], awaiting[2];
  logic [31:0] bufd[2];
  int          disc[2];

  function automatic logic [31:0] extract(input logic [4:0] op, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * int'(off));
    if (op[4]) return {{24{s[7]}}, s[7:0]};
    if (op[3]) return {24'b0, s[7:0]};
    if (op[2]) return {{16{s[15]}}, s[15:0]};
    if (op[1]) return {16'b0, s[15:0]};
    return s;
  endfunction

  function automatic bit consumable(input int i);
    return busy[i] && awaiting[i] && (data_ok === 1'b1) && disc[i] == 0;
  endfunction
  function automatic bit e_valid(input int i);
    return busy[i] && (!awaiting[i] || (i == 0 && consumable(i))) && (wb_ex !== 1'b1);
  endfunction
  function automatic bit e_full(input int i);
    return disc[i] == DMAX;
  endfunction
  function automatic bit e_allowin(input int i);
    return ((!busy[i] || (e_valid(i) && ws_allowin === 1'b1)) && !e_full(i)) || wb_ex === 1'b1;
  endfunction
  function automatic bit e_resv(input int i);
    return busy[i] && (!awaiting[i] || consumable(i));
  endfunction
  function automatic logic [31:0] e_wdata(input int i);
    logic [31:0] src;
    src = consumable(i) ? rdata : bufd[i];
    return rec[i].rfm ? extract(rec[i].ld, rec[i].res[1:0], src) : rec[i].res;
  endfunction

  task automatic model_step();
    bit cons, hand, acc, dec, inc;
    for (int i = 0; i < 2; i++) begin
      if (resetn !== 1'b1) begin
        busy[i] = 0; awaiting[i] = 0; bufd[i] = '0; disc[i] = 0; rec[i] = '0;
      end else begin
        cons = consumable(i);
        hand = e_valid(i) && ws_allowin === 1'b1;
        acc  = es_to_ms_valid === 1'b1 && e_allowin(i) && wb_ex !== 1'b1;
        dec  = data_ok === 1'b1 && disc[i] > 0;
        inc  = wb_ex === 1'b1 && busy[i] && awaiting[i] && !cons;
        if (inc && !dec && disc[i] < DMAX) disc[i]++;
        else if (dec && !inc) disc[i]--;
        if (cons) begin bufd[i] = rdata; awaiting[i] = 0; end
        if (wb_ex === 1'b1) begin
          busy[i] = 0; rec[i].we = 1'b0;
        end else if (acc) begin
          rec[i] = '{pc: es_pc, rfm: es_res_from_mem, ld: es_ld_op, res: es_result,
                     we: es_rf_we, wa: es_rf_waddr, csr: es_csr_re, zip: es_ex_zip};
          busy[i] = 1; awaiting[i] = es_mem_req;
        end else if (hand) begin
          busy[i] = 0; rec[i].we = 1'b0;
        end
      end
    end
  endtask

  // Compare point: negedge, inputs stable since 1ns after the previous posedge.
  task automatic settle();
    string s;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s = $sformatf("[%0d]", i);
      chk1({"valid", s},   o_valid[i],     e_valid(i));
      chk1({"allowin", s}, o_allowin[i],   e_allowin(i));
      chk1({"resv", s},    o_res_valid[i], e_resv(i));
      chk1({"full", s},    o_full[i],      e_full(i));
      chk1({"rf_we", s},   o_rf_we[i],     rec[i].we);
      chk({"waddr", s},    96'(o_waddr[i]), 96'(rec[i].wa));
      chk32({"pc", s},     o_pc[i],        rec[i].pc);
      chk32({"result", s}, o_result[i],    rec[i].res);
      chk1({"csr_re", s},  o_csr_re[i],    rec[i].csr);
      chk({"ex_zip", s},   96'(o_zip[i]),  96'(rec[i].zip));
      chk1({"ex", s},      o_ex[i],        |rec[i].zip[6:0]);
      if (e_resv(i)) chk32({"wdata", s}, o_wdata[i], e_wdata(i));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic idle();
    resetn = 1'b1; es_to_ms_valid = 1'b0; es_pc = '0; es_mem_req = 1'b0;
    es_res_from_mem = 1'b0; es_ld_op = '0; es_result = '0; es_rf_we = 1'b0;
    es_rf_waddr = '0; es_csr_re = 1'b0; es_ex_zip = '0; data_ok = 1'b0;
    rdata = '0; ws_allowin = 1'b1; wb_ex = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] op, input logic [31:0] res);
    es_to_ms_valid = 1'b1; es_mem_req = 1'b1; es_res_from_mem = 1'b1;
    es_ld_op = op; es_result = res; es_rf_we = 1'b1; es_rf_waddr = 5'd9;
    es_pc = 32'h1c00_0000 + res; es_ex_zip = '0; es_csr_re = 1'b0;
  endtask

  task automatic flush_one();
    set_load(5'b00001, 32'h0);
    cyc();
    es_to_ms_valid = 1'b0; wb_ex = 1'b1;
    cyc();
    wb_ex = 1'b0;
  endtask

  task automatic randomize_inputs();
    logic [95:0] t;
    bit ld;
    resetn         = ($urandom_range(0, 99) != 0);
    es_to_ms_valid = ($urandom_range(0, 9) < 6);
    es_mem_req     = ($urandom_range(0, 9) < 7);
    ld             = es_mem_req && ($urandom_range(0, 1) == 1);
    es_res_from_mem = ld;
    es_ld_op       = ld ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
    es_result      = $urandom;
    es_pc          = $urandom;
    es_rf_we       = ld || !es_mem_req;
    es_rf_waddr    = 5'($urandom);
    es_csr_re      = 1'($urandom);
    t = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 1) == 0) t[6:0] = '0;
    es_ex_zip      = t[EX_W-1:0];
    data_ok        = ($urandom_range(0, 9) < 3);
    rdata          = $urandom;
    ws_allowin     = ($urandom_range(0, 9) < 7);
    wb_ex          = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    advance(); advance();
    resetn = 1'b1;
    settle();
    for (int i = 0; i < 2; i++) begin
      chk1("rst_allowin", o_allowin[i], 1'b1);
      chk1("rst_valid", o_valid[i], 1'b0);
      chk1("rst_full", o_full[i], 1'b0);
      chk1("rst_resv", o_res_valid[i], 1'b0);
    end
    advance();

    // ld.b offset 2, data_ok three cycles after entry
    set_load(5'b10000, 32'h0000_0002);
    cyc();
    es_to_ms_valid = 1'b0;
    cyc(); cyc();
    data_ok = 1'b1; rdata = 32'h0080_0000;
    settle();
    chk1("lb_valid_byp1", o_valid[0], 1'b1);
    chk32("lb_data_byp1", o_wdata[0], 32'hFFFF_FF80);
    chk1("lb_valid_byp0_early", o_valid[1], 1'b0);
    advance();
    data_ok = 1'b0; rdata = '0;
    settle();
    chk1("lb_valid_byp0", o_valid[1], 1'b1);
    chk32("lb_data_byp0", o_wdata[1], 32'hFFFF_FF80);
    chk1("lb_byp1_gone", o_valid[0], 1'b0);
    advance();

    // ld.hu offset 2, WB stalled for four cycles after data_ok
    set_load(5'b00010, 32'h0000_1006);
    ws_allowin = 1'b0;
    cyc();
    es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h8001_0000;
    cyc();
    data_ok = 1'b0; rdata = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        chk1("lhu_hold_valid", o_valid[i], 1'b1);
        chk32("lhu_hold_data", o_wdata[i], 32'h0000_8001);
      end
      advance();
    end
    ws_allowin = 1'b1;
    cyc();
    settle();
    for (int i = 0; i < 2; i++) begin
      chk1("lhu_after_rf_we", o_rf_we[i], 1'b0);
      chk1("lhu_after_valid", o_valid[i], 1'b0);
    end
    advance();

    // flush in WAIT, next load gets the second response
    set_load(5'b00001, 32'h0);
    cyc();
    es_to_ms_valid = 1'b0; wb_ex = 1'b1;
    cyc();
    wb_ex = 1'b0;
    set_load(5'b00001, 32'h4);
    settle();
    chk1("fl_full0", o_full[0], 1'b0);
    chk1("fl_allowin", o_allowin[0], 1'b1);
    advance();
    es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_0001;
    settle();
    chk1("fl_drop_valid", o_valid[0], 1'b0);
    chk1("fl_drop_resv", o_res_valid[1], 1'b0);
    advance();
    rdata = 32'h1234_5678;
    settle();
    chk1("fl_own_valid", o_valid[0], 1'b1);
    chk32("fl_own_data", o_wdata[0], 32'h1234_5678);
    chk1("fl_own_resv_byp0", o_res_valid[1], 1'b1);
    advance();
    data_ok = 1'b0;
    cyc(); cyc();

    // counter saturation and inc/dec cancellation
    flush_one(); flush_one(); flush_one();
    settle();
    for (int i = 0; i < 2; i++) begin
      chk1("sat_full", o_full[i], 1'b1);
      chk1("sat_allowin", o_allowin[i], 1'b0);
    end
    advance();
    data_ok = 1'b1;
    cyc();
    data_ok = 1'b0;
    settle();
    chk1("sat_dec_full", o_full[0], 1'b0);
    chk1("sat_dec_allowin", o_allowin[0], 1'b1);
    advance();
    set_load(5'b00001, 32'h8);
    cyc();
    es_to_ms_valid = 1'b0; wb_ex = 1'b1; data_ok = 1'b1;
    cyc();
    wb_ex = 1'b0; data_ok = 1'b0;
    settle();
    chk1("cancel_full", o_full[0], 1'b0);
    advance();
    flush_one();
    settle();
    chk1("cancel_then_full", o_full[0], 1'b1);
    advance();
    data_ok = 1'b1;
    cyc(); cyc(); cyc();
    data_ok = 1'b0;
    settle();
    chk1("drained_full", o_full[1], 1'b0);
    advance();

    // ALU op with an exception flag
    es_to_ms_valid = 1'b1; es_mem_req = 1'b0; es_res_from_mem = 1'b0; es_ld_op = '0;
    es_result = 32'h0000_CAFE; es_rf_we = 1'b1; es_rf_waddr = 5'd7;
    es_ex_zip = EX_W'(1); ws_allowin = 1'b0;
    cyc();
    es_to_ms_valid = 1'b0;
    settle();
    chk1("alu_valid", o_valid[0], 1'b1);
    chk1("alu_resv", o_res_valid[1], 1'b1);
    chk1("alu_ex", o_ex[0], 1'b1);
    chk32("alu_data", o_wdata[1], 32'h0000_CAFE);
    advance();
    ws_allowin = 1'b1;
    cyc();

    // reset in WAIT with a pending discard
    set_load(5'b00001, 32'h0);
    cyc();
    es_to_ms_valid = 1'b0; wb_ex = 1'b1;
    cyc();
    wb_ex = 1'b0;
    set_load(5'b00001, 32'h0);
    cyc();
    es_to_ms_valid = 1'b0; resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    settle();
    chk1("rst2_allowin", o_allowin[0], 1'b1);
    chk1("rst2_valid", o_valid[0], 1'b0);
    chk1("rst2_resv", o_res_valid[0], 1'b0);
    advance();
    set_load(5'b00001, 32'h0);
    cyc();
    es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h0BAD_F00D;
    settle();
    chk1("rst2_load_valid", o_valid[0], 1'b1);
    chk32("rst2_load_data", o_wdata[0], 32'h0BAD_F00D);
    advance();
    data_ok = 1'b0;
    cyc(); cyc();

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
